datapath_ctrl: RTL and testbench

- Upstream instruction sequencer for the 4x4-bit register-file datapath.
- Accepts 16-bit micro-instructions over a valid/ready handshake and buffers them in a small FIFO.
- Each cycle it drives the datapath's 13-bit control word and 4-bit constant.
- Handles multi-cycle behaviour: repeated ALU ops, and loads that stall until external DATA is valid.

---
 rtl/datapath_pkg.sv | 64 ++++++
 rtl/ctrl_fifo.sv | 45 ++++
 rtl/datapath_ctrl.sv | 143 ++++++++++++++
 tb/tb_datapath_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath instruction sequencer: opcodes, FSM
// states, instruction/control-word field positions and control-word assembly.
package datapath_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LDD  = 2'b01,
        OP_ALU  = 2'b10,
        OP_ALUI = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT_DATA
    } state_t;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned CW_WIDTH = 13;
    localparam int unsigned IMM_W    = 4;

    // Instruction fields {OP, DA, AA, BA, FS, IMM}
    localparam int unsigned OP_LSB  = 14;
    localparam int unsigned DA_LSB  = 12;
    localparam int unsigned AA_LSB  = 10;
    localparam int unsigned BA_LSB  = 8;
    localparam int unsigned FS_LSB  = 4;
    localparam int unsigned IMM_LSB = 0;

    // Control word fields {DA, AA, BA, MB, FS, MD, RW}
    localparam int unsigned CW_DA_LSB = 11;
    localparam int unsigned CW_AA_LSB = 9;
    localparam int unsigned CW_BA_LSB = 7;
    localparam int unsigned CW_MB     = 6;
    localparam int unsigned CW_FS_LSB = 2;
    localparam int unsigned CW_MD     = 1;
    localparam int unsigned CW_RW     = 0;

    function automatic op_t get_op(input logic [INSTR_W-1:0] instr);
        return op_t'(instr[OP_LSB +: 2]);
    endfunction

    function automatic logic [IMM_W-1:0] get_imm(input logic [INSTR_W-1:0] instr);
        return instr[IMM_LSB +: IMM_W];
    endfunction

    function automatic logic [CW_WIDTH-1:0] build_cw(input logic [INSTR_W-1:0] instr);
        logic [CW_WIDTH-1:0] cw;
        op_t                 op;
        cw = '0;
        op = get_op(instr);
        if (op != OP_NOP) begin
            cw[CW_DA_LSB +: 2] = instr[DA_LSB +: 2];
            cw[CW_AA_LSB +: 2] = instr[AA_LSB +: 2];
            cw[CW_BA_LSB +: 2] = instr[BA_LSB +: 2];
            cw[CW_FS_LSB +: 4] = instr[FS_LSB +: 4];
            cw[CW_MB]          = (op == OP_ALUI);
            cw[CW_MD]          = (op == OP_LDD);
            cw[CW_RW]          = 1'b1;
        end
        return cw;
    endfunction

endpackage

// File: rtl/ctrl_fifo.sv
// Synchronous DEPTH-entry instruction FIFO with extra-MSB wrap pointers.
// A push while full is taken only when a pop frees a slot on the same edge.
module ctrl_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/datapath_ctrl.sv
// Instruction sequencer driving the register-file datapath control word.
// Optional DATAPATH_CTRL_PERF_EN adds RETIRED/STALLS saturating counters.
module datapath_ctrl
    import datapath_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW_W  = 13
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [15:0]     INSTR,
    input  logic            INSTR_VLD,
    output logic            INSTR_RDY,
    input  logic            DATA_VLD,
    output logic [CW_W-1:0] CW,
    output logic [3:0]      CONSTANT,
    output logic            BUSY,
    output logic            DONE
`ifdef DATAPATH_CTRL_PERF_EN
    ,
    output logic [7:0]      RETIRED,
    output logic [7:0]      STALLS
`endif
);

    state_t           state, state_n;
    logic [15:0]      ir, ir_n;
    logic [3:0]       rep, rep_n;
    logic [CW_W-1:0]  cw_n;
    logic [3:0]       const_n;
    logic             done_n;
    logic             launch;
    op_t              op;

    logic             fifo_push;
    logic             fifo_pop;
    logic [15:0]      head;
    logic             fifo_full;
    logic             fifo_empty;

    assign INSTR_RDY = !fifo_full;
    assign fifo_push = INSTR_VLD && INSTR_RDY;
    assign BUSY      = !fifo_empty || (state != S_IDLE);

    ctrl_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (INSTR),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_n  = state;
        ir_n     = ir;
        rep_n    = rep;
        cw_n     = '0;
        const_n  = CONSTANT;
        done_n   = 1'b0;
        fifo_pop = 1'b0;
        launch   = 1'b0;
        op       = get_op(head);

        case (state)
            S_IDLE: begin
                if (!fifo_empty) launch = 1'b1;
            end
            S_WAIT_DATA: begin
                if (DATA_VLD) begin
                    cw_n    = build_cw(ir);
                    done_n  = 1'b1;
                    rep_n   = '0;
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                if (rep != '0) begin
                    rep_n  = rep - 1'b1;
                    cw_n   = CW;
                    done_n = (rep == 4'd1);
                end else if (!fifo_empty) begin
                    launch = 1'b1;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // IDLE and back-to-back EXEC share one decode path for the FIFO head
        if (launch) begin
            fifo_pop = 1'b1;
            ir_n     = head;
            if (op == OP_LDD && !DATA_VLD) begin
                rep_n   = '0;
                state_n = S_WAIT_DATA;
            end else begin
                cw_n    = build_cw(head);
                rep_n   = (op == OP_ALU) ? get_imm(head) : '0;
                done_n  = (op != OP_ALU) || (get_imm(head) == '0);
                state_n = S_EXEC;
                if (op == OP_ALUI) const_n = get_imm(head);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            ir       <= '0;
            rep      <= '0;
            CW       <= '0;
            CONSTANT <= '0;
            DONE     <= 1'b0;
        end else begin
            state    <= state_n;
            ir       <= ir_n;
            rep      <= rep_n;
            CW       <= cw_n;
            CONSTANT <= const_n;
            DONE     <= done_n;
        end
    end

`ifdef DATAPATH_CTRL_PERF_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RETIRED <= '0;
            STALLS  <= '0;
        end else begin
            if (DONE && RETIRED != '1)                  RETIRED <= RETIRED + 1'b1;
            if (state == S_WAIT_DATA && STALLS != '1)   STALLS  <= STALLS + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: accepted words expand into expected issues.
module tb_datapath_ctrl;

    localparam int DEPTH = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [15:0] INSTR = '0;
    logic        INSTR_VLD = 1'b0;
    logic        DATA_VLD = 1'b1;
    logic        INSTR_RDY;
    logic [12:0] CW;
    logic [3:0]  CONSTANT;
    logic        BUSY;
    logic        DONE;
`ifdef DATAPATH_CTRL_PERF_EN
    logic [7:0]  RETIRED;
    logic [7:0]  STALLS;
`endif

    always #5 CLK = ~CLK;

    datapath_ctrl #(
        .DEPTH (DEPTH),
        .CW_W  (13)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .INSTR     (INSTR),
        .INSTR_VLD (INSTR_VLD),
        .INSTR_RDY (INSTR_RDY),
        .DATA_VLD  (DATA_VLD),
        .CW        (CW),
        .CONSTANT  (CONSTANT),
        .BUSY      (BUSY),
        .DONE      (DONE)
`ifdef DATAPATH_CTRL_PERF_EN
        ,
        .RETIRED   (RETIRED),
        .STALLS    (STALLS)
`endif
    );

    typedef struct {
        logic [12:0] cw;
        logic [3:0]  k;
        logic        done;
    } ev_t;

    ev_t        sb[$];
    ev_t        e_mon;
    logic [3:0] model_k = '0;
    int         checks = 0;
    int         passes = 0;
    int         cyc = 0;
    bit         rand_dv = 1'b0;
    bit         dv_fixed = 1'b1;
    bit         gap_on = 1'b0;
    bit         saw_full = 1'b0;
    int         first_cyc = -1;
    int         last_cyc = -1;
    int         ev_cnt = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] mk(input int unsigned op, da, aa, ba, fs, imm);
        return {op[1:0], da[1:0], aa[1:0], ba[1:0], fs[3:0], imm[3:0]};
    endfunction

    // Reference: each accepted word becomes a list of issues computed from field arithmetic
    function automatic void model_accept(input logic [15:0] w);
        int unsigned op, da, aa, ba, fs, imm, cwv;
        int n;
        op = w[15:14]; da = w[13:12]; aa = w[11:10]; ba = w[9:8]; fs = w[7:4]; imm = w[3:0];
        cwv = da * 2048 + aa * 512 + ba * 128 + fs * 4 + 1;
        case (op)
            0:       cwv = 0;
            1:       cwv = cwv + 2;
            3:       cwv = cwv + 64;
            default: ;
        endcase
        n = (op == 2) ? int'(imm) + 1 : 1;
        if (op == 3) model_k = imm[3:0];
        for (int i = 0; i < n; i++)
            sb.push_back('{cw: cwv[12:0], k: model_k, done: (i == n - 1)});
    endfunction

    always @(posedge CLK) begin
        #1;
        DATA_VLD = rand_dv ? 1'($urandom_range(0, 1)) : dv_fixed;
    end

    always @(negedge CLK) begin
        cyc++;
        if (RST_N) begin
            if (CW[0] || DONE) begin
                if (gap_on) begin
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    ev_cnt++;
                end
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_issue: got CW=%b DONE=%b expected no issue", CW, DONE);
                end else begin
                    e_mon = sb.pop_front();
                    check("issue_cw", CW, e_mon.cw);
                    check("issue_const", CONSTANT, e_mon.k);
                    check("issue_done", DONE, e_mon.done);
                end
            end
            if (gap_on && !INSTR_RDY) saw_full = 1'b1;
            if (INSTR_VLD && INSTR_RDY) model_accept(INSTR);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        bit r;
        int guard;
        guard = 0;
        INSTR = w;
        INSTR_VLD = 1'b1;
        do begin
            @(negedge CLK);
            r = INSTR_RDY;
            @(posedge CLK);
            guard++;
        end while (!r && guard < 500);
        if (!r) begin
            checks++;
            $display("FAIL send_timeout: got not accepted after %0d cycles expected accept", guard);
        end
        #1;
    endtask

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        INSTR_VLD = 1'b0;
        do begin
            @(negedge CLK);
            g++;
        end while (BUSY && g < 400);
        check({name, "_busy"}, BUSY, 0);
        check({name, "_drained"}, sb.size(), 0);
        check({name, "_cw0"}, CW, 0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int wr;
        logic [31:0] rw;

        #1 RST_N = 1'b0;
        #2;
        check("rst_cw", CW, 0);
        check("rst_const", CONSTANT, 0);
        check("rst_done", DONE, 0);
        check("rst_busy", BUSY, 0);
        check("rst_rdy", INSTR_RDY, 1);
        tick(3);
        RST_N = 1'b1;
        tick(2);

        // LDD with data ready: one cycle of latency, one issue
        send(mk(1, 0, 0, 0, 0, 0));
        INSTR_VLD = 1'b0;
        @(negedge CLK); check("ldd_latency", CW, 0);
        @(negedge CLK); check("ldd_cw", CW, 13'b0000000000011); check("ldd_done", DONE, 1);
        @(negedge CLK); check("ldd_after", CW, 0);
        wait_idle("ldd");

        send(mk(2, 3, 0, 1, 1, 0));
        send(mk(2, 3, 0, 1, 1, 3));
        wait_idle("alu_rep");

        // LDD stalled on DATA_VLD
        dv_fixed = 1'b0;
        tick(2);
        send(mk(1, 1, 0, 0, 0, 0));
        INSTR_VLD = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("stall_cw", CW, 0);
            check("stall_busy", BUSY, 1);
        end
        dv_fixed = 1'b1;
        wait_idle("stall");

        // Back-to-back burst behind a repeating ALU
        gap_on = 1'b1;
        send(mk(2, 0, 1, 2, 3, 5));
        for (int i = 0; i < DEPTH + 2; i++) send(mk(2, i % 4, 1, 2, i + 1, 0));
        wait_idle("burst");
        gap_on = 1'b0;
        check("burst_events", ev_cnt, 6 + DEPTH + 2);
        check("burst_no_gap", last_cyc - first_cyc + 1, ev_cnt);
        check("burst_rdy_dropped", saw_full, 1);

        send(mk(3, 2, 3, 0, 4'b1010, 4'b0110));
        send(mk(2, 1, 2, 3, 5, 2));
        wait_idle("alui");
        check("alui_const_hold", CONSTANT, 4'b0110);

        // Randomized traffic with random DATA_VLD
        rand_dv = 1'b1;
        for (int i = 0; i < 120; i++) begin
            rw = $urandom;
            send(rw[15:0]);
            if ($urandom_range(0, 2) == 0) begin
                INSTR_VLD = 1'b0;
                tick($urandom_range(1, 3));
            end
        end
        wait_idle("random");
        rand_dv = 1'b0;
        dv_fixed = 1'b1;
        tick(2);

        // Reset during the third issue of an 8-issue ALU
        send(mk(2, 3, 3, 3, 15, 7));
        INSTR_VLD = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        check("pre_reset_rw", CW[0], 1);
        RST_N = 1'b0;
        #1;
        check("async_rst_cw", CW, 0);
        check("async_rst_busy", BUSY, 0);
        check("async_rst_done", DONE, 0);
        sb.delete();
        model_k = '0;
        tick(2);
        RST_N = 1'b1;
        check("post_rst_rdy", INSTR_RDY, 1);
        check("post_rst_const", CONSTANT, 0);
        wr = 0;
        repeat (20) begin
            @(negedge CLK);
            if (CW[0]) wr++;
        end
        check("no_write_after_reset", wr, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
